// File: rtl/score_display_mux.sv
// Score keeper with BCD accumulation and a multiplexed active-low
// seven-segment scanner. Adds fire on rising edges of score_valid,
// game_end freezes the score and blinks the display, and clear wins
// over everything else.
module score_display_mux #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned SATURATE    = 0,
    parameter int unsigned BLANK_LZ    = 1,
    parameter int unsigned BLINK_TICKS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            score_inc,
    input  logic                  score_valid,
    input  logic                  game_end,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  overflow
);

    localparam int unsigned SCORE_W = 4 * DIGITS;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned TICK_W  = $clog2(REFRESH_DIV);
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [SCORE_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic                 valid_q, valid_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 overflow_q, overflow_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic                 add_evt_c;
    logic [3:0]           inc_c;
    logic [SCORE_W-1:0]   sum_c;
    logic                 carry_c;
    logic [4:0]           dsum_c;
    logic                 tick_c;
    logic [3:0]           sel_c;
    logic                 blank_c;
    logic                 zero_from_c;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Ripple BCD adder: clamped increment into digit 0, carry through all digits.
    always_comb begin
        inc_c   = (score_inc > 4'd9) ? 4'd9 : score_inc;
        sum_c   = '0;
        carry_c = 1'b0;
        dsum_c  = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            dsum_c = 5'(score_q[4*k +: 4]) + 5'(carry_c);
            if (k == 0) begin
                dsum_c = dsum_c + 5'(inc_c);
            end
            if (dsum_c > 5'd9) begin
                sum_c[4*k +: 4] = 4'(dsum_c - 5'd10);
                carry_c         = 1'b1;
            end else begin
                sum_c[4*k +: 4] = dsum_c[3:0];
                carry_c         = 1'b0;
            end
        end
    end

    // Score update with priority clear > game_end freeze > add.
    always_comb begin
        add_evt_c  = score_valid & ~valid_q;
        valid_d    = score_valid;
        score_d    = score_q;
        overflow_d = overflow_q;
        if (clear) begin
            score_d    = '0;
            overflow_d = 1'b0;
        end else if (game_end) begin
            score_d    = score_q;
        end else if (add_evt_c) begin
            score_d = (carry_c && (SATURATE != 0)) ? ALL_NINES : sum_c;
            if (carry_c) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Refresh tick, scan index and blink phase.
    always_comb begin
        tick_c      = (tick_q == TICK_W'(REFRESH_DIV - 1));
        tick_d      = tick_c ? '0 : tick_q + TICK_W'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (tick_c) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (!game_end) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (tick_c) begin
            if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Digit select, leading-zero blanking and next an/seg values.
    always_comb begin
        sel_c       = '0;
        blank_c     = 1'b0;
        zero_from_c = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zero_from_c = zero_from_c & (score_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                sel_c   = score_q[4*k +: 4];
                blank_c = (BLANK_LZ != 0) && (k > 0) && zero_from_c;
            end
        end
        an_d  = blink_on_q ? ~(DIGITS'(1) << idx_q) : '1;
        seg_d = (!blink_on_q || blank_c) ? SEG_OFF : seg_decode(sel_c);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b1;
            score_q     <= '0;
            overflow_q  <= 1'b0;
            tick_q      <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
        end else begin
            valid_q     <= valid_d;
            score_q     <= score_d;
            overflow_q  <= overflow_d;
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign score_bcd = score_q;
    assign overflow  = overflow_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Bench for score_display_mux: wrap and saturate instances side by side,
// an integer-level reference model, a vector table and corner sequences.
module tb_score_display_mux;

    localparam int D  = 4;
    localparam int RD = 4;
    localparam int BT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  score_inc;
    logic        score_valid;
    logic        game_end;
    logic        clear;
    logic [15:0] score0, score1;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        ovf0, ovf1;

    score_display_mux #(.DIGITS(D), .REFRESH_DIV(RD), .SATURATE(0), .BLANK_LZ(1), .BLINK_TICKS(BT)) dut0 (
        .clk(clk), .rst(rst), .score_inc(score_inc), .score_valid(score_valid),
        .game_end(game_end), .clear(clear), .score_bcd(score0), .an(an0), .seg(seg0), .overflow(ovf0));

    score_display_mux #(.DIGITS(D), .REFRESH_DIV(RD), .SATURATE(1), .BLANK_LZ(1), .BLINK_TICKS(BT)) dut1 (
        .clk(clk), .rst(rst), .score_inc(score_inc), .score_valid(score_valid),
        .game_end(game_end), .clear(clear), .score_bcd(score1), .an(an1), .seg(seg1), .overflow(ovf1));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int m_s0, m_s1;
    bit m_o0, m_o1, m_vprev, m_gprev;
    int m_e;

    typedef struct {
        bit c;
        bit g;
        bit v;
        int inc;
        int exp;
        bit ovf;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected display for position idx of decimal score s (blanking on).
    function automatic void exp_disp(input int idx, input int s, output logic [3:0] a, output logic [6:0] sg);
        int p;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        a = 4'hF;
        a[idx] = 1'b0;
        if (idx > 0 && (s / p) == 0) sg = 7'h7F;
        else sg = seg_of((s / p) % 10);
    endfunction

    // One clock: drive inputs, advance model, compare score and (when not blinking) display.
    task automatic cycle(input bit c, input bit g, input bit v, input int inc);
        logic [3:0] ea0, ea1;
        logic [6:0] es0, es1;
        int idx, a, sum;
        bit chk_disp;
        clear = c; game_end = g; score_valid = v; score_inc = 4'(inc);
        idx = (m_e / RD) % D;
        exp_disp(idx, m_s0, ea0, es0);
        exp_disp(idx, m_s1, ea1, es1);
        chk_disp = !m_gprev;
        @(posedge clk);
        #1;
        if (c) begin
            m_s0 = 0; m_s1 = 0; m_o0 = 0; m_o1 = 0;
        end else if (!g && v && !m_vprev) begin
            a = (inc > 9) ? 9 : inc;
            sum = m_s0 + a;
            if (sum > 9999) begin m_o0 = 1; m_s0 = sum - 10000; end
            else m_s0 = sum;
            sum = m_s1 + a;
            if (sum > 9999) begin m_o1 = 1; m_s1 = 9999; end
            else m_s1 = sum;
        end
        m_vprev = v;
        m_gprev = g;
        m_e++;
        chk("score_wrap", score0, to_bcd(m_s0));
        chk("ovf_wrap", ovf0, m_o0);
        chk("score_sat", score1, to_bcd(m_s1));
        chk("ovf_sat", ovf1, m_o1);
        if (chk_disp) begin
            chk("an_wrap", an0, ea0);
            chk("seg_wrap", seg0, es0);
            chk("an_sat", an1, ea1);
            chk("seg_sat", seg1, es1);
        end
    endtask

    // Assert reset away from the clock edge, check async values, release.
    task automatic do_reset(input bit v_hold);
        score_valid = v_hold;
        clear = 0; game_end = 0; score_inc = 0;
        rst = 1;
        #2;
        chk("rst_an", an0, 4'hF);
        chk("rst_seg", seg0, 7'h7F);
        chk("rst_score", score0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_an_sat", an1, 4'hF);
        @(posedge clk);
        #1;
        rst = 0;
        m_s0 = 0; m_s1 = 0; m_o0 = 0; m_o1 = 0;
        m_vprev = 1; m_gprev = 0; m_e = 0;
    endtask

    task automatic load(input int n);
        int rem;
        rem = n;
        while (rem > 0) begin
            cycle(0, 0, 1, (rem > 9) ? 9 : rem);
            cycle(0, 0, 0, 0);
            rem = rem - ((rem > 9) ? 9 : rem);
        end
    endtask

    initial begin
        logic [3:0] prev_an;
        logic [3:0] pat_an[4];
        logic [6:0] pat_seg[4];
        bit found, g;
        bit exp_off;

        rst = 1; clear = 0; game_end = 0; score_valid = 0; score_inc = 0;

        tbl[0]  = '{0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 3, 3, 0};
        tbl[2]  = '{0, 0, 0, 0, 3, 0};
        tbl[3]  = '{0, 0, 1, 3, 6, 0};
        tbl[4]  = '{0, 0, 0, 0, 6, 0};
        tbl[5]  = '{0, 0, 1, 3, 9, 0};
        tbl[6]  = '{0, 0, 1, 3, 9, 0};
        tbl[7]  = '{0, 0, 0, 0, 9, 0};
        tbl[8]  = '{0, 0, 1, 15, 18, 0};
        tbl[9]  = '{0, 0, 0, 0, 18, 0};
        tbl[10] = '{0, 1, 1, 5, 18, 0};
        tbl[11] = '{0, 1, 0, 0, 18, 0};
        tbl[12] = '{0, 0, 1, 7, 25, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 4, 4, 0};
        tbl[15] = '{1, 1, 0, 0, 0, 0};
        tbl[16] = '{1, 0, 1, 9, 0, 0};
        tbl[17] = '{0, 0, 1, 9, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 0};
        tbl[19] = '{0, 0, 1, 2, 2, 0};

        do_reset(0);

        // vector table
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].c, tbl[i].g, tbl[i].v, tbl[i].inc);
            chk($sformatf("tbl%0d_score", i), score0, to_bcd(tbl[i].exp));
            chk($sformatf("tbl%0d_ovf", i), ovf0, tbl[i].ovf);
        end

        // carry ripple across digits
        cycle(1, 0, 0, 0);
        load(998);
        cycle(0, 0, 1, 5);
        chk("ripple_1003", score0, 16'h1003);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        load(999);
        cycle(0, 0, 1, 15);
        chk("ripple_1008", score0, 16'h1008);
        cycle(0, 0, 0, 0);

        // overflow: wrap vs saturate, then clear
        cycle(1, 0, 0, 0);
        load(9997);
        cycle(0, 0, 1, 5);
        chk("ovf_wrap_val", score0, 16'h0002);
        chk("ovf_wrap_flag", ovf0, 1);
        chk("ovf_sat_val", score1, 16'h9999);
        chk("ovf_sat_flag", ovf1, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 3);
        chk("ovf_sticky", ovf0, 1);
        cycle(1, 0, 0, 0);
        chk("clr_val", score0, 16'h0000);
        chk("clr_flag", ovf0, 0);
        chk("clr_flag_sat", ovf1, 0);

        // held valid gives a single add
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 2);
        chk("held_valid", score0, 16'h0002);
        cycle(0, 0, 0, 0);

        // valid held high through reset release
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 5);
        chk("valid_thru_rst", score0, 16'h0000);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 5);
        chk("valid_after_low", score0, 16'h0005);

        // scan pattern for 0042
        cycle(1, 0, 0, 0);
        load(42);
        pat_an[0] = 4'hE;  pat_an[1] = 4'hD;  pat_an[2] = 4'hB;  pat_an[3] = 4'h7;
        pat_seg[0] = 7'h24; pat_seg[1] = 7'h19; pat_seg[2] = 7'h7F; pat_seg[3] = 7'h7F;
        found = 0;
        prev_an = an0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(0, 0, 0, 0);
            if (an0 == 4'hE && prev_an != 4'hE) found = 1;
            prev_an = an0;
        end
        chk("scan_sync", found, 1);
        if (found) begin
            for (int j = 0; j < 16; j++) begin
                if (j > 0) cycle(0, 0, 0, 0);
                chk($sformatf("scan_an%0d", j), an0, pat_an[j/4]);
                chk($sformatf("scan_seg%0d", j), seg0, pat_seg[j/4]);
            end
        end

        // blink while game_end with pulses ignored
        found = 0;
        prev_an = an0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(0, 1, i[0], 3);
            if (an0 == 4'hF && prev_an != 4'hF) found = 1;
            prev_an = an0;
        end
        chk("blink_sync", found, 1);
        if (found) begin
            for (int j = 1; j < 24; j++) begin
                cycle(0, 1, j[0], 3);
                exp_off = ((j / 8) % 2) == 0;
                chk($sformatf("blink_off%0d", j), (an0 == 4'hF), exp_off);
                if (exp_off) chk($sformatf("blink_seg%0d", j), seg0, 7'h7F);
            end
        end
        chk("game_freeze", score0, 16'h0042);
        cycle(1, 1, 0, 0);
        chk("clr_in_game", score0, 16'h0000);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // reset mid-scan
        load(7);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        do_reset(0);

        // randomized run against the model
        g = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) g = ~g;
            cycle($urandom_range(0, 24) == 0, g, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/score_display_mux.md
SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD score digits and display positions (legal 1..8).
REQ-002 Parameter REFRESH_DIV, default 50000, clk cycles per display position (legal >=2).
REQ-003 Parameter SATURATE, default 0: 0 = score wraps modulo 10^DIGITS, 1 = score holds at all nines.
REQ-004 Parameter BLANK_LZ, default 1, 1 = blank leading zeros.
REQ-005 Parameter BLINK_TICKS, default 64, refresh ticks per blink half-period while game_end is high.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 score_inc  input  4  binary amount to add; values 10..15 are clamped to 9.
REQ-009 score_valid  input  1  add request; acts only on its rising edge (sampled high while the previous sample was low).
REQ-010 game_end  input  1  freezes the score and blinks the display while high.
REQ-011 clear  input  1  synchronous clear of the score and overflow flag.
REQ-012 score_bcd  output  4*DIGITS  current score, digit 0 (least significant) in bits [3:0].
REQ-013 an  output  DIGITS  active-low one-hot digit enable, an[0] = digit 0.
REQ-014 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-015 overflow  output  1  sticky flag, set when an add exceeds 10^DIGITS-1.

Function
REQ-016 Edge detect: valid_q register; an add occurs on the edge where score_valid=1 and valid_q=0; score_inc is sampled on that same edge.
REQ-017 Latency: score_bcd shows the new value immediately after that edge (zero added cycles); carry ripples through all DIGITS digits within one cycle.
REQ-018 Priority per edge: clear > game_end freeze > add; adds are discarded, not queued, during clear or game_end.
REQ-019 Overflow with SATURATE=0: result is the true sum modulo 10^DIGITS, and overflow is set.
REQ-020 Overflow with SATURATE=1: score_bcd becomes all nines, and overflow is set.
REQ-021 clear=1: score_bcd=0 and overflow=0 on the next edge, regardless of game_end.
REQ-022 Scan: a tick counter runs 0..REFRESH_DIV-1; the tick pulses at terminal count; the index idx advances 0..DIGITS-1 on each tick and wraps to 0.
REQ-023 an and seg are registered from idx and score_bcd, with one clk of latency; exactly one an bit is low except during blanking (REQ-026).
REQ-024 Decode (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; any other value gives 7F.
REQ-025 Leading-zero blank: when BLANK_LZ=1, digit k>0 shows seg=7F if digits k..DIGITS-1 are all zero; digit 0 is never blanked.
REQ-026 Blink: while game_end=1, a phase bit toggles every BLINK_TICKS ticks; in the off phase an=all ones and seg=7F.
REQ-027 Blink phase: forced to "on" and its counter cleared whenever game_end=0.
REQ-028 Score changes mid-scan: take effect at the next registered an/seg update; there is no tearing within a position.

Reset
REQ-029 On rst=1, asynchronously: score_bcd=0, overflow=0, idx=0, tick and blink counters=0, blink phase=on, an=all ones, seg=7F.
REQ-030 valid_q resets to 1, so a score_valid held high through reset release causes no add until it has been seen low.
REQ-031 rst asserted mid-scan or mid-add forces the REQ-029 values immediately; the first display update follows one clk after release.

Verification (DIGITS=4, REFRESH_DIV=4, BLINK_TICKS=2 unless noted)
REQ-032 Reset, then three score_valid pulses with inc=3 -> score_bcd=0009, overflow=0.
REQ-033 Score 0998, pulse with inc=5 -> 1003 on the same edge; score 0999 with inc=15 -> 1008.
REQ-034 Score 9997 with inc=5: SATURATE=0 -> 0002 and overflow=1; SATURATE=1 -> 9999 and overflow=1; then clear -> 0000 and overflow=0.
REQ-035 score_valid held high for 10 cycles with inc=2 -> exactly one add; score_valid high across rst release -> no add.
REQ-036 Score 0042, BLANK_LZ=1 -> an cycles 1110, 1101, 1011, 0111, 4 clk each; seg shows 24, 19, 7F, 7F.
REQ-037 game_end=1 with pulses -> score unchanged and display alternates on/off every 8 clk; clear during game_end -> 0000; rst mid-scan -> an=1111 and seg=7F at once.
